// File: rtl/dot_feeder_pkg.sv
// Shared types and default sizes for the dot-product feeder.
// The A-reuse mode is selected by defining DFEED_REUSE_A_EN (see dot_product_feeder.sv).
package dot_feeder_pkg;

  localparam int DFEED_INW  = 16;
  localparam int DFEED_OUTW = 48;
  localparam int DFEED_LEN  = 8;

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    CLEAR,
    COMPUTE,
    DRAIN,
    OUTPUT
  } dfeed_state_e;

endpackage

// File: rtl/dot_feeder_vec_mem.sv
// LEN x INW vector buffer: one synchronous write port, one combinational read port.
// Contents are deliberately not reset; the feeder always rewrites an entry before reading it.
module dot_feeder_vec_mem
  import dot_feeder_pkg::*;
#(
  parameter int INW   = DFEED_INW,
  parameter int LEN   = DFEED_LEN,
  parameter int ADDRW = $clog2(DFEED_LEN)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ADDRW-1:0] waddr,
  input  logic [INW-1:0]   wdata,
  input  logic [ADDRW-1:0] raddr,
  output logic [INW-1:0]   rdata
);

  logic [INW-1:0] mem_q [LEN];

  // Store the incoming element at the load index.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dot_product_feeder.sv
// Sequencer ahead of the MAC: buffers vectors A and B from an input stream, feeds the MAC one
// element pair per cycle after a single clear pulse, then holds the captured accumulator for a
// downstream valid/ready consumer.
// Optional feature: define DFEED_REUSE_A_EN to keep A loaded across operations, so that after
// the first result only a new B vector is streamed in.
module dot_product_feeder
  import dot_feeder_pkg::*;
#(
  parameter int INW  = DFEED_INW,
  parameter int OUTW = DFEED_OUTW,
  parameter int LEN  = DFEED_LEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [INW-1:0]  input_data,
  input  logic            input_valid,
  output logic            input_ready,
  output logic [INW-1:0]  mac_in0,
  output logic [INW-1:0]  mac_in1,
  output logic            mac_valid_input,
  output logic            mac_clear_acc,
  input  logic [OUTW-1:0] mac_out,
  output logic [OUTW-1:0] output_data,
  output logic            output_valid,
  input  logic            output_ready
);

  localparam int               ADDRW    = $clog2(LEN);
  localparam logic [ADDRW-1:0] IDX_LAST = ADDRW'(LEN - 1);

`ifdef DFEED_REUSE_A_EN
  // A stays resident; each new operation only streams a fresh B.
  localparam dfeed_state_e RETURN_STATE = LOAD_B;
`else
  localparam dfeed_state_e RETURN_STATE = LOAD_A;
`endif

  dfeed_state_e     state_q, state_d;
  logic [ADDRW-1:0] idx_q, idx_d;
  logic [OUTW-1:0]  output_data_q, output_data_d;
  logic             last_idx;
  logic             load_phase;
  logic             in_xfer;
  logic             we_a, we_b;
  logic [INW-1:0]   rd_a, rd_b;

  assign last_idx   = (idx_q == IDX_LAST);
  assign load_phase = (state_q == LOAD_A) || (state_q == LOAD_B);
  // The async reset already parks the FSM in LOAD_A; gating with reset keeps ready low
  // for the whole time reset is held, not just after it is released.
  assign input_ready = load_phase & reset;
  assign in_xfer     = input_valid & input_ready;
  assign we_a        = in_xfer & (state_q == LOAD_A);
  assign we_b        = in_xfer & (state_q == LOAD_B);

  assign output_data  = output_data_q;
  assign output_valid = (state_q == OUTPUT);

  dot_feeder_vec_mem #(
    .INW   (INW),
    .LEN   (LEN),
    .ADDRW (ADDRW)
  ) u_mem_a (
    .clk   (clk),
    .we    (we_a),
    .waddr (idx_q),
    .wdata (input_data),
    .raddr (idx_q),
    .rdata (rd_a)
  );

  dot_feeder_vec_mem #(
    .INW   (INW),
    .LEN   (LEN),
    .ADDRW (ADDRW)
  ) u_mem_b (
    .clk   (clk),
    .we    (we_b),
    .waddr (idx_q),
    .wdata (input_data),
    .raddr (idx_q),
    .rdata (rd_b)
  );

  // Next-state, index and MAC-drive decode; the shared index walks loads and compute alike.
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    output_data_d   = output_data_q;
    mac_in0         = '0;
    mac_in1         = '0;
    mac_valid_input = 1'b0;
    mac_clear_acc   = 1'b0;

    case (state_q)
      LOAD_A: begin
        if (in_xfer) begin
          if (last_idx) begin
            idx_d   = '0;
            state_d = LOAD_B;
          end else begin
            idx_d = idx_q + ADDRW'(1);
          end
        end
      end

      LOAD_B: begin
        if (in_xfer) begin
          if (last_idx) begin
            idx_d   = '0;
            state_d = CLEAR;
          end else begin
            idx_d = idx_q + ADDRW'(1);
          end
        end
      end

      CLEAR: begin
        mac_clear_acc = 1'b1;
        state_d       = COMPUTE;
      end

      COMPUTE: begin
        mac_valid_input = 1'b1;
        mac_in0         = rd_a;
        mac_in1         = rd_b;
        if (last_idx) begin
          idx_d   = '0;
          state_d = DRAIN;
        end else begin
          idx_d = idx_q + ADDRW'(1);
        end
      end

      // The MAC registered the last pair on the previous edge, so mac_out is final here.
      DRAIN: begin
        output_data_d = mac_out;
        state_d       = OUTPUT;
      end

      OUTPUT: begin
        if (output_ready) begin
          state_d = RETURN_STATE;
        end
      end

      default: begin
        state_d = LOAD_A;
        idx_d   = '0;
      end
    endcase
  end

  // State, index and result registers; reset discards any partial load or pending result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= LOAD_A;
      idx_q         <= '0;
      output_data_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      output_data_q <= output_data_d;
    end
  end

endmodule

// File: tb/tb_dot_product_feeder.sv
// Self-checking bench for dot_product_feeder (LEN=4) with a behavioural MAC downstream.
module tb_dot_product_feeder;

  localparam int INW  = 16;
  localparam int OUTW = 48;
  localparam int LEN  = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [INW-1:0]  input_data;
  logic            input_valid;
  logic            input_ready;
  logic [INW-1:0]  mac_in0;
  logic [INW-1:0]  mac_in1;
  logic            mac_valid_input;
  logic            mac_clear_acc;
  logic [OUTW-1:0] mac_out;
  logic [OUTW-1:0] output_data;
  logic            output_valid;
  logic            output_ready;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: vectors for the next op and the A currently held by the DUT.
  int a_vec [LEN];
  int b_vec [LEN];
  int ref_a [LEN];
  bit a_loaded = 1'b0;

  dot_product_feeder #(.INW(INW), .OUTW(OUTW), .LEN(LEN)) dut (
    .clk             (clk),
    .reset           (reset),
    .input_data      (input_data),
    .input_valid     (input_valid),
    .input_ready     (input_ready),
    .mac_in0         (mac_in0),
    .mac_in1         (mac_in1),
    .mac_valid_input (mac_valid_input),
    .mac_clear_acc   (mac_clear_acc),
    .mac_out         (mac_out),
    .output_data     (output_data),
    .output_valid    (output_valid),
    .output_ready    (output_ready)
  );

  always #5 clk = ~clk;

  // Downstream MAC: registered accumulator with clear.
  logic signed [OUTW-1:0] acc, ext0, ext1;
  always_comb begin
    ext0 = {{(OUTW-INW){mac_in0[INW-1]}}, mac_in0};
    ext1 = {{(OUTW-INW){mac_in1[INW-1]}}, mac_in1};
  end
  always @(posedge clk or negedge reset) begin
    if (!reset)               acc <= '0;
    else if (mac_clear_acc)   acc <= '0;
    else if (mac_valid_input) acc <= acc + ext0 * ext1;
  end
  assign mac_out = acc;

  // MAC-side monitor.
  int clr_cnt, vld_cnt;
  bit idle_bad;
  logic [INW-1:0] pa_q[$], pb_q[$];
  always @(posedge clk) begin
    if (reset) begin
      if (mac_clear_acc) clr_cnt++;
      if (mac_clear_acc && mac_valid_input) idle_bad = 1'b1;
      if (mac_valid_input) begin
        vld_cnt++;
        pa_q.push_back(mac_in0);
        pb_q.push_back(mac_in1);
      end else if (mac_in0 != '0 || mac_in1 != '0) begin
        idle_bad = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit need_a();
`ifdef DFEED_REUSE_A_EN
    return !a_loaded;
`else
    return 1'b1;
`endif
  endfunction

  // Streams the words the model says the DUT needs; vmode 0=always valid, 1=toggle, 2=random.
  task automatic feed(input int vmode);
    logic [INW-1:0] words[$];
    int budget;
    bit rdy_ok;
    if (need_a()) begin
      for (int i = 0; i < LEN; i++) begin
        ref_a[i] = a_vec[i];
        words.push_back(INW'(a_vec[i]));
      end
    end
    for (int i = 0; i < LEN; i++) words.push_back(INW'(b_vec[i]));
    a_loaded = 1'b1;
    clr_cnt = 0; vld_cnt = 0; idle_bad = 1'b0;
    pa_q.delete(); pb_q.delete();
    budget = 0;
    rdy_ok = 1'b1;
    while (words.size() > 0 && budget < 200) begin
      @(negedge clk);
      budget++;
      case (vmode)
        0:       input_valid = 1'b1;
        1:       input_valid = (budget % 2 == 1);
        default: input_valid = 1'($urandom_range(0, 1));
      endcase
      input_data = input_valid ? words[0] : INW'($urandom);
      if (input_ready !== 1'b1) rdy_ok = 1'b0;
      if (input_valid && input_ready) void'(words.pop_front());
    end
    n_tests++;
    if (words.size() != 0) begin
      n_fail++;
      $display("FAIL load_done: %0d words left, required 0", words.size());
    end
    n_tests++;
    if (!rdy_ok) begin
      n_fail++;
      $display("FAIL load_ready: input_ready dropped during load, required 1");
    end
  endtask

  // One full operation: feed, check latency, stall, result, handshake and MAC sequencing.
  task automatic do_op(input string name, input int vmode, input int stall);
    longint exp_sum;
    logic [OUTW-1:0] exp_out, held;
    int lat;
    bit busy_ok, stall_ok, pair_ok;
    output_ready = (stall == 0);
    feed(vmode);
    exp_sum = 0;
    for (int i = 0; i < LEN; i++) exp_sum += longint'(ref_a[i]) * longint'(b_vec[i]);
    exp_out = OUTW'(exp_sum);
    lat = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      input_valid = 1'($urandom_range(0, 1));
      input_data  = INW'($urandom);
      if (input_ready !== 1'b0) busy_ok = 1'b0;
    end while (output_valid !== 1'b1 && lat < 50);
    n_tests++;
    if (lat != LEN + 3) begin
      n_fail++;
      $display("FAIL %s latency: got %0d cycles, required %0d", name, lat, LEN + 3);
    end
    n_tests++;
    if (output_data !== exp_out) begin
      n_fail++;
      $display("FAIL %s result: got %0d, required %0d", name, $signed(output_data), exp_sum);
    end
    held = output_data;
    stall_ok = 1'b1;
    repeat (stall) begin
      @(negedge clk);
      input_valid = 1'b1;
      if (output_valid !== 1'b1 || output_data !== held || input_ready !== 1'b0) stall_ok = 1'b0;
    end
    output_ready = 1'b1;
    n_tests++;
    if (!busy_ok || !stall_ok) begin
      n_fail++;
      $display("FAIL %s busy: input_ready/output hold broken (busy_ok=%0d stall_ok=%0d), required 1/1",
               name, busy_ok, stall_ok);
    end
    @(negedge clk);
    input_valid = 1'b0;
    n_tests++;
    if (output_valid !== 1'b0 || input_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s release: output_valid=%b input_ready=%b, required 0/1",
               name, output_valid, input_ready);
    end
    output_ready = 1'b0;
    n_tests++;
    if (clr_cnt != 1 || vld_cnt != LEN || idle_bad) begin
      n_fail++;
      $display("FAIL %s mac_seq: clears=%0d valids=%0d idle_bad=%0d, required 1/%0d/0",
               name, clr_cnt, vld_cnt, idle_bad, LEN);
    end
    pair_ok = (pa_q.size() == LEN) && (pb_q.size() == LEN);
    if (pair_ok) begin
      for (int i = 0; i < LEN; i++) begin
        if (pa_q[i] !== INW'(ref_a[i]) || pb_q[i] !== INW'(b_vec[i])) pair_ok = 1'b0;
      end
    end
    n_tests++;
    if (!pair_ok) begin
      n_fail++;
      $display("FAIL %s mac_pairs: %0d pairs seen or wrong order/values, required %0d in order",
               name, pa_q.size(), LEN);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    input_valid = 1'b0;
    input_data = '0;
    output_ready = 1'b0;
    #12;
    n_tests++;
    if (output_valid !== 1'b0 || input_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hs: output_valid=%b input_ready=%b, required 0/0", output_valid, input_ready);
    end
    n_tests++;
    if (output_data !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %0d, required 0", output_data);
    end
    n_tests++;
    if (mac_valid_input !== 1'b0 || mac_clear_acc !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mac: valid=%b clear=%b, required 0/0", mac_valid_input, mac_clear_acc);
    end
    @(negedge clk);
    reset = 1'b1;
    a_loaded = 1'b0;
    #1;
    n_tests++;
    if (input_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: input_ready=%b, required 1", input_ready);
    end
  endtask

  task automatic test_basic();
    a_vec = '{1, 2, 3, 4};
    b_vec = '{5, 6, 7, 8};
    do_op("basic", 0, 0);
  endtask

  task automatic test_back_to_back();
    a_vec = '{-1, -2, -3, -4};
    b_vec = '{5, 6, 7, 8};
    do_op("negative", 0, 0);
    a_vec = '{0, 0, 0, 0};
    b_vec = '{9, 9, 9, 9};
    do_op("zeros", 0, 0);
  endtask

  task automatic test_stall();
    a_vec = '{1, 2, 3, 4};
    b_vec = '{5, 6, 7, 8};
    do_op("stall", 1, 5);
  endtask

  task automatic test_reset_mid();
    int nw;
    nw = need_a() ? LEN + 2 : 2;
    for (int i = 0; i < nw; i++) begin
      @(negedge clk);
      input_valid = 1'b1;
      input_data  = INW'(i + 3);
    end
    @(negedge clk);
    input_valid = 1'b0;
    reset = 1'b0;
    #1;
    n_tests++;
    if (output_valid !== 1'b0 || input_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: output_valid=%b input_ready=%b, required 0/0", output_valid, input_ready);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    a_loaded = 1'b0;
    a_vec = '{1, 1, 1, 1};
    b_vec = '{2, 2, 2, 2};
    do_op("after_reset", 0, 0);
  endtask

  task automatic test_reset_output();
    int w;
    a_vec = '{3, 1, 4, 1};
    b_vec = '{5, 9, 2, 6};
    output_ready = 1'b0;
    feed(0);
    w = 0;
    do begin
      @(negedge clk);
      input_valid = 1'b0;
      w++;
    end while (output_valid !== 1'b1 && w < 50);
    #2;
    reset = 1'b0;
    #1;
    n_tests++;
    if (output_valid !== 1'b0 || output_data !== '0) begin
      n_fail++;
      $display("FAIL out_reset: output_valid=%b output_data=%0d, required 0/0", output_valid, output_data);
    end
    @(negedge clk);
    reset = 1'b1;
    a_loaded = 1'b0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < LEN; i++) begin
        a_vec[i] = int'($urandom_range(0, 65535)) - 32768;
        b_vec[i] = int'($urandom_range(0, 65535)) - 32768;
      end
      do_op("random", 2, int'($urandom_range(0, 3)));
    end
  endtask

`ifdef DFEED_REUSE_A_EN
  task automatic test_reuse_a();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    a_loaded = 1'b0;
    a_vec = '{1, 2, 3, 4};
    b_vec = '{1, 1, 1, 1};
    do_op("reuse_op1", 0, 0);
    a_vec = '{7, 7, 7, 7};
    b_vec = '{2, 0, 0, 0};
    do_op("reuse_op2", 0, 0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_reset_output();
    test_random();
`ifdef DFEED_REUSE_A_EN
    test_reuse_a();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
